// File: rtl/intermed_pipe.sv
// Two-stage valid/ready pipeline: inter = op(in_1, in_2); out_1 = inter & in_3; out_2 = inter | in_1.
// Optional output-transfer counter (xfer_count) enabled by defining INTERMED_PIPE_STATS_EN.
module intermed_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2
`ifdef INTERMED_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count
`endif
);

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_inter;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_c;
  logic [WIDTH-1:0] inter_c;
  logic             s2_free_c;
  logic             s1_adv_c;
  logic             in_xfer_c;

  // Operator applied bitwise to the operands
  always_comb begin
    inter_c = '0;
    case (op)
      OP_AND:  inter_c = in_1 & in_2;
      OP_OR:   inter_c = in_1 | in_2;
      OP_XOR:  inter_c = in_1 ^ in_2;
      default: inter_c = ~(in_1 & in_2);
    endcase
  end

  // Handshake: in_ready depends on out_ready and stage occupancy only, never on in_valid
  always_comb begin
    s2_free_c = ~out_valid | out_ready;
    s1_adv_c  = s1_valid & s2_free_c;
    in_ready  = ~s1_valid | s2_free_c;
    in_xfer_c = in_valid & in_ready;
  end

  // Stage 1: latch intermediate and the operands needed downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_inter <= '0;
      s1_a     <= '0;
      s1_c     <= '0;
    end else if (in_xfer_c) begin
      s1_valid <= 1'b1;
      s1_inter <= inter_c;
      s1_a     <= in_1;
      s1_c     <= in_3;
    end else if (s1_adv_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: final results, held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_1     <= '0;
      out_2     <= '0;
    end else if (s1_adv_c) begin
      out_valid <= 1'b1;
      out_1     <= s1_inter & s1_c;
      out_2     <= s1_inter | s1_a;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef INTERMED_PIPE_STATS_EN
  // Completed output transfers, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (out_valid & out_ready) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end
`endif

endmodule
